// File: rtl/rr8_pkg.sv
// rtl/rr8_pkg.sv - shared constants, state enum and sweep helper for rr8_dec_sched (RR_SWEEP_EN adds SWEEP)
package rr8_pkg;

  localparam int NUM_REQ     = 8;
  localparam int ID_W        = 3;
  localparam int SWEEP_STEPS = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
`ifdef RR_SWEEP_EN
    ,
    ST_SWEEP = 2'd3
`endif
  } state_e;

`ifdef RR_SWEEP_EN
  // Sweep walks up 0..7 and back down to 0 over 15 steps.
  function automatic logic [ID_W-1:0] sweep_addr(input logic [3:0] step);
    return (step < 4'd8) ? step[ID_W-1:0] : ID_W'(4'd14 - step);
  endfunction
`endif

endpackage

// File: rtl/rr8_dec_sched_if.sv
// rtl/rr8_dec_sched_if.sv - requester/decoder-side bus of rr8_dec_sched (RR_SWEEP_EN adds sweep_go/sweep_busy)
interface rr8_dec_sched_if;

  logic [rr8_pkg::NUM_REQ-1:0] req;
  logic                        lock;
  logic                        dec_en;
  logic [rr8_pkg::ID_W-1:0]    dec_add;
  logic                        done;
`ifdef RR_SWEEP_EN
  logic                        sweep_go;
  logic                        sweep_busy;

  modport master (output req, lock, sweep_go, input dec_en, dec_add, done, sweep_busy);
  modport slave  (input req, lock, sweep_go, output dec_en, dec_add, done, sweep_busy);
`else
  modport master (output req, lock, input dec_en, dec_add, done);
  modport slave  (input req, lock, output dec_en, dec_add, done);
`endif

endinterface

// File: rtl/rr8_prio_pick.sv
// rtl/rr8_prio_pick.sv - rotating-priority pick of the first set req bit at or after ptr
module rr8_prio_pick
  import rr8_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               any,
  output logic [ID_W-1:0]    idx
);

  logic [ID_W-1:0] cand;

  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    // Scan farthest-first so the nearest set bit at/after ptr is the last one written.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr + ID_W'(i);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr8_dec_sched.sv
// rtl/rr8_dec_sched.sv - round-robin grant scheduler driving an external decoder38; RR_SWEEP_EN adds a 0..7..0 sweep
module rr8_dec_sched
  import rr8_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  rr8_dec_sched_if.slave bus
);

  localparam logic [7:0] HOLD_C = 8'(HOLD_CYCLES);
  localparam logic [3:0] GAP_C  = 4'(GAP_CYCLES);
  localparam bit         NO_GAP = (GAP_CYCLES == 0);

  state_e          state_q, state_d;
  logic            dec_en_q, dec_en_d;
  logic            done_q, done_d;
  logic [ID_W-1:0] dec_add_q, dec_add_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [7:0]      hold_q, hold_d;
  logic [3:0]      gap_q, gap_d;
  logic [ID_W-1:0] pick_ptr, pick_idx;
  logic            pick_any;
  logic            grant_end, gap_end, new_grant;
`ifdef RR_SWEEP_EN
  logic [3:0]      step_q, step_d;
  logic            busy_q, busy_d;
  logic            sweep_end;
`endif

  // While granting, arbitrate from the slot after the grantee so back-to-back grants rotate.
  assign pick_ptr = (state_q == ST_GRANT) ? dec_add_q + 1'b1 : ptr_q;

  rr8_prio_pick u_pick (
    .req (bus.req),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign grant_end = (state_q == ST_GRANT) &&
                     (!bus.req[dec_add_q] || (!bus.lock && hold_q == HOLD_C));
  assign gap_end   = (state_q == ST_GAP) && (gap_q == GAP_C);
`ifdef RR_SWEEP_EN
  assign sweep_end = (state_q == ST_SWEEP) && (hold_q == HOLD_C) &&
                     (step_q == 4'(SWEEP_STEPS - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
`ifdef RR_SWEEP_EN
        if (bus.sweep_go) state_d = ST_SWEEP;
        else
`endif
        if (pick_any) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        if (grant_end) begin
          if (NO_GAP) state_d = pick_any ? ST_GRANT : ST_IDLE;
          else        state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_end) state_d = pick_any ? ST_GRANT : ST_IDLE;
      end
`ifdef RR_SWEEP_EN
      ST_SWEEP: begin
        if (sweep_end) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dec_en_d  = dec_en_q;
    dec_add_d = dec_add_q;
    done_d    = 1'b0;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    new_grant = 1'b0;
`ifdef RR_SWEEP_EN
    step_d    = step_q;
    busy_d    = busy_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef RR_SWEEP_EN
        if (bus.sweep_go) begin
          dec_en_d  = 1'b1;
          dec_add_d = '0;
          hold_d    = 8'd1;
          step_d    = '0;
          busy_d    = 1'b1;
        end
        else
`endif
        new_grant = pick_any;
      end
      ST_GRANT: begin
        if (grant_end) begin
          done_d    = 1'b1;
          dec_en_d  = 1'b0;
          ptr_d     = dec_add_q + 1'b1;
          gap_d     = 4'd1;
          new_grant = NO_GAP && pick_any;
        end else if (!bus.lock) begin
          hold_d = hold_q + 8'd1;
        end
      end
      ST_GAP: begin
        if (gap_end) new_grant = pick_any;
        else         gap_d     = gap_q + 4'd1;
      end
`ifdef RR_SWEEP_EN
      ST_SWEEP: begin
        if (hold_q != HOLD_C) begin
          hold_d = hold_q + 8'd1;
        end else if (sweep_end) begin
          dec_en_d = 1'b0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
        end else begin
          step_d    = step_q + 4'd1;
          dec_add_d = sweep_addr(step_q + 4'd1);
          hold_d    = 8'd1;
        end
      end
`endif
      default: ;
    endcase
    if (new_grant) begin
      dec_en_d  = 1'b1;
      dec_add_d = pick_idx;
      hold_d    = 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_en_q  <= 1'b0;
      dec_add_q <= '0;
      done_q    <= 1'b0;
      ptr_q     <= '0;
      hold_q    <= '0;
      gap_q     <= '0;
`ifdef RR_SWEEP_EN
      step_q    <= '0;
      busy_q    <= 1'b0;
`endif
    end else begin
      dec_en_q  <= dec_en_d;
      dec_add_q <= dec_add_d;
      done_q    <= done_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
`ifdef RR_SWEEP_EN
      step_q    <= step_d;
      busy_q    <= busy_d;
`endif
    end
  end

  assign bus.dec_en  = dec_en_q;
  assign bus.dec_add = dec_add_q;
  assign bus.done    = done_q;
`ifdef RR_SWEEP_EN
  assign bus.sweep_busy = busy_q;
`endif

endmodule

// File: tb/tb_rr8_dec_sched.sv
// tb/tb_rr8_dec_sched.sv - scoreboard bench for rr8_dec_sched against a cycle-level behavioural model
module tb_rr8_dec_sched;

  localparam int H  = 4;
  localparam int G  = 1;
  localparam int SW = 15;

  logic clk;
  logic rst_n;
  logic busy_now;
  int   tests;
  int   fails;
  bit   mon_on;
  logic [5:0] exp_q[$];

  // Model: granted index (-1 when none), cycles used, gap cycles left, rotation pointer.
  int m_cur, m_used, m_gap, m_ptr, m_add, m_swt;
  bit m_sw, m_done;

  rr8_dec_sched_if bus ();

  rr8_dec_sched #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef RR_SWEEP_EN
  assign busy_now = bus.sweep_busy;
`else
  assign busy_now = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_cur = -1; m_used = 0; m_gap = 0; m_ptr = 0; m_add = 0;
    m_sw = 0; m_swt = 0; m_done = 0;
  endtask

  task automatic model_edge(input logic [7:0] r, input logic lk, input logic sg);
    bit arb;
    bit idle;
    arb  = 0;
    idle = 0;
    m_done = 0;
    if (m_sw) begin
      m_swt++;
      if (m_swt == SW * H) begin
        m_sw = 0;
        m_done = 1;
      end else begin
        m_add = (m_swt / H < 8) ? m_swt / H : 14 - m_swt / H;
      end
    end else if (m_cur >= 0) begin
      if (!r[m_cur] || (!lk && m_used == H)) begin
        m_done = 1;
        m_ptr  = (m_cur + 1) % 8;
        m_cur  = -1;
        m_gap  = G;
        arb    = (G == 0);
      end else if (!lk) begin
        m_used++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
      arb = (m_gap == 0);
    end else begin
      arb  = 1;
      idle = 1;
    end
`ifdef RR_SWEEP_EN
    if (idle && sg) begin
      m_sw  = 1;
      m_swt = 0;
      m_add = 0;
    end else
`endif
    if (arb) begin
      for (int k = 0; k < 8; k++) begin
        int j;
        j = (m_ptr + k) % 8;
        if (r[j]) begin
          m_cur  = j;
          m_add  = j;
          m_used = 1;
          break;
        end
      end
    end
  endtask

  task automatic cyc(input logic [7:0] r, input logic lk, input logic sg, input int n);
    bit en;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n    = 1'b1;
      bus.req  = r;
      bus.lock = lk;
`ifdef RR_SWEEP_EN
      bus.sweep_go = sg;
`endif
      model_edge(r, lk, sg);
      en = m_sw || (m_cur >= 0);
      exp_q.push_back({en, 3'(m_add), m_done, m_sw});
    end
  endtask

  task automatic do_reset(input logic [7:0] r);
    @(negedge clk);
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.lock = 1'b0;
`ifdef RR_SWEEP_EN
    bus.sweep_go = 1'b0;
`endif
    #1;
    tests++;
    if ({bus.dec_en, bus.dec_add, bus.done, busy_now} !== 6'd0) begin
      fails++;
      $display("FAIL async_reset got en=%b add=%0d done=%b busy=%b required all 0",
               bus.dec_en, bus.dec_add, bus.done, busy_now);
    end
    model_reset();
    exp_q.push_back(6'd0);
    cyc(r, 1'b0, 1'b0, 1);
  endtask

  initial begin
    logic [5:0] e, got;
    forever begin
      @(posedge clk);
      #1;
      if (mon_on) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
          e   = exp_q.pop_front();
          got = {bus.dec_en, bus.dec_add, bus.done, busy_now};
          if (got !== e) begin
            fails++;
            $display("FAIL outputs t=%0t got en=%b add=%0d done=%b busy=%b required en=%b add=%0d done=%b busy=%b",
                     $time, got[5], got[4:2], got[1], got[0], e[5], e[4:2], e[1], e[0]);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rq;
    tests    = 0;
    fails    = 0;
    mon_on   = 0;
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.lock = 1'b0;
`ifdef RR_SWEEP_EN
    bus.sweep_go = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    tests++;
    if ({bus.dec_en, bus.dec_add, bus.done, busy_now} !== 6'd0) begin
      fails++;
      $display("FAIL reset_state got en=%b add=%0d done=%b required all 0",
               bus.dec_en, bus.dec_add, bus.done);
    end
    mon_on = 1;

    cyc(8'h01, 1'b0, 1'b0, 20);
    do_reset(8'hFF);
    cyc(8'hFF, 1'b0, 1'b0, 46);
    do_reset(8'h84);
    cyc(8'h84, 1'b1, 1'b0, 10);
    cyc(8'h84, 1'b0, 1'b0, 14);
    do_reset(8'h02);
    cyc(8'h02, 1'b0, 1'b0, 1);
    cyc(8'h00, 1'b0, 1'b0, 3);
    cyc(8'hFF, 1'b0, 1'b0, 3);
    do_reset(8'h10);
    cyc(8'h10, 1'b0, 1'b0, 8);
    cyc(8'h00, 1'b0, 1'b0, 6);
    cyc(8'hFF, 1'b1, 1'b1, 1);
    cyc(8'hFF, 1'b1, 1'b1, 62);
    cyc(8'hFF, 1'b0, 1'b0, 6);

    rq = 8'h5A;
    for (int n = 0; n < 700; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset(rq);
      if ($urandom_range(0, 7) == 0) rq = 8'($urandom) & 8'($urandom);
      cyc(rq, $urandom_range(0, 5) == 0, $urandom_range(0, 80) == 0, 1);
    end

    @(posedge clk);
    #3;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr8_dec_sched.md
RR8_DEC_SCHED -- requirements
Module: rr8_dec_sched

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, SHALL set the grant length in clk cycles; legal range 1..255.
REQ-002 Parameter GAP_CYCLES, default 1, SHALL set the dead cycles between grants with dec_en low; legal range 0..15.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 req  input  8  SHALL carry per-requester level requests; bit i belongs to requester i.
REQ-006 lock  input  1  SHALL, when high during GRANT, extend the current grant.
REQ-007 dec_en  output  1  SHALL be the registered decoder enable, wired to decoder38 en.
REQ-008 dec_add  output  3  SHALL be the registered granted requester index, wired to decoder38 add.
REQ-009 done  output  1  SHALL be a registered one-cycle pulse marking the end of each grant.

Function
REQ-010 The FSM SHALL have states IDLE, GRANT, GAP, plus SWEEP when RR_SWEEP_EN is defined.
REQ-011 In IDLE with req!=0, the block SHALL pick the first set bit at or after ptr, rotating upward modulo 8; dec_en=1 and dec_add=pick SHALL appear after the next rising edge (1-cycle latency).
REQ-012 ptr SHALL reset to 0 and SHALL load (granted index + 1) mod 8 when each grant ends; 7 wraps to 0.
REQ-013 In GRANT, a hold counter SHALL count cycles with dec_en high; the grant SHALL end after exactly HOLD_CYCLES cycles unless lock or req-drop applies.
REQ-014 While lock=1 in GRANT, the hold counter SHALL freeze, and the grant SHALL persist for as long as the granted req bit stays high; lock SHALL be ignored in other states.
REQ-015 If the granted req bit is low at a rising edge in GRANT, the grant SHALL end at that edge regardless of lock or the count.
REQ-016 At grant end, dec_en SHALL fall and done SHALL pulse high for one cycle on the same edge.
REQ-017 After a grant, the FSM SHALL enter GAP for GAP_CYCLES cycles with dec_en=0, then re-arbitrate as in IDLE.
REQ-018 With GAP_CYCLES=0, GRANT SHALL go straight to the next grant, with dec_add changing and dec_en held high; done SHALL still pulse.
REQ-019 If req=0 at re-arbitration, the FSM SHALL go to IDLE.
REQ-020 dec_add SHALL be stable for the whole time dec_en is high; while dec_en is low, dec_add SHALL hold its last value.
REQ-021 New req bits asserted during GRANT or GAP SHALL only be considered at the next arbitration point.

Reset
REQ-022 rst_n low SHALL immediately force the state to IDLE, dec_en=0, dec_add=0, done=0, ptr=0 and counters=0, including in the middle of a grant or sweep.
REQ-023 The first arbitration SHALL occur at the first rising edge after rst_n deasserts.

Configuration
REQ-024 With macro RR_SWEEP_EN defined, the block SHALL add input sweep_go (1 bit) and output sweep_busy (1 bit).
REQ-025 With RR_SWEEP_EN defined, sweep_go=1 in IDLE SHALL start SWEEP, which presents dec_add 0,1,…,7,6,…,0 (15 steps), each for HOLD_CYCLES cycles with dec_en high and no gaps, while ignoring req and lock.
REQ-026 With RR_SWEEP_EN defined, sweep_busy SHALL be high throughout SWEEP; done SHALL pulse once when the sweep ends; the FSM SHALL then return to IDLE with ptr unchanged.
REQ-027 With RR_SWEEP_EN defined, sweep_go SHALL take priority over req in IDLE and SHALL be ignored in other states.
REQ-028 Without RR_SWEEP_EN, sweep_go, sweep_busy and the SWEEP state SHALL be absent.

Structure
REQ-029 Package rr8_pkg SHALL hold the state enum, NUM_REQ=8 and ID_W=3.
REQ-030 Rotating-priority selection SHALL be the combinational sub-module rr8_prio_pick (inputs req, ptr; outputs any, idx).
REQ-031 decoder38 SHALL NOT be instantiated inside the block; the enclosing top SHALL connect it.

Verification (HOLD_CYCLES=4, GAP_CYCLES=1)
REQ-032 Scenario: req=8'h01 held -> dec_add=0 with dec_en high for 4 cycles, then done pulse, 1 gap cycle, and the pattern repeats.
REQ-033 Scenario: req=8'hFF from reset -> grants 0,1,…,7,0 in order, each 4 cycles with 1 gap between; this checks the 7→0 wrap.
REQ-034 Scenario: req=8'h84 with lock=1 for 10 cycles during grant 2 -> dec_add=2 is held for 4+10 cycles, then the grant goes to 7.
REQ-035 Scenario: granted req bit dropped in the 2nd grant cycle -> dec_en falls and done pulses on the next edge.
REQ-036 Scenario: rst_n pulsed low mid-grant -> outputs are 0 immediately; after release with req=8'h10, the grant is 4 (ptr=0).
REQ-037 Scenario (RR_SWEEP_EN): sweep_go in IDLE -> dec_add sequence 0..7..0, 60 cycles total with dec_en high, one done pulse, and sweep_busy high throughout.
